lwc_post_processor: RTL and testbench

//  Output end of the SpoC-64 LWC datapath. Accepts the CryptoCore result stream
//  (bdo words, tag words, msg_auth verdict) and builds the LWC API do_data stream.
//  Per operation it emits a segment header, the data words (tail-masked), a tag

---
 rtl/lwc_post_processor.sv | 172 +++++++++++++++++
 tb/tb_lwc_post_processor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lwc_post_processor.sv
// Output stage of the SpoC-64 LWC datapath: wraps CryptoCore bdo/tag/verdict
// results into the LWC API do_data stream (header, masked data, tag, status).
module lwc_post_processor #(
    parameter int unsigned TAG_WORDS      = 4,
    parameter logic [31:0] STATUS_SUCCESS = 32'hE000_0000,
    parameter logic [31:0] STATUS_FAILURE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_decrypt,
    input  logic [15:0] op_len,
    input  logic [31:0] bdo,
    input  logic        bdo_valid,
    output logic        bdo_ready,
    input  logic        msg_auth,
    input  logic        msg_auth_valid,
    output logic        msg_auth_ready,
    output logic [31:0] do_data,
    output logic        do_valid,
    input  logic        do_ready,
    output logic        do_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_TAG_HDR, S_TAG, S_AUTH, S_STATUS
    } state_t;

    state_t      state_q, state_d;
    logic        decrypt_q, decrypt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        verdict_q, verdict_d;
    logic [31:0] do_data_q, do_data_d;
    logic        do_valid_q, do_valid_d;
    logic        do_last_q, do_last_d;

    logic        can_load;
    logic        bdo_fire;
    logic [31:0] data_mask;
    logic [15:0] rem_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            decrypt_q  <= 1'b0;
            len_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            verdict_q  <= 1'b0;
            do_data_q  <= '0;
            do_valid_q <= 1'b0;
            do_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            decrypt_q  <= decrypt_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            verdict_q  <= verdict_d;
            do_data_q  <= do_data_d;
            do_valid_q <= do_valid_d;
            do_last_q  <= do_last_d;
        end
    end

    // Tail handling: only the first rem bytes of the final word are kept.
    always_comb begin
        case (rem_q)
            16'd1:   data_mask = 32'hFF00_0000;
            16'd2:   data_mask = 32'hFFFF_0000;
            16'd3:   data_mask = 32'hFFFF_FF00;
            default: data_mask = '1;
        endcase
        rem_step = (rem_q < 16'd4) ? rem_q : 16'd4;
    end

    always_comb begin
        state_d    = state_q;
        decrypt_d  = decrypt_q;
        len_d      = len_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        verdict_d  = verdict_q;
        do_data_d  = do_data_q;
        do_valid_d = do_valid_q && !do_ready;
        do_last_d  = do_last_q && do_valid_d;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    decrypt_d = op_decrypt;
                    len_d     = op_len;
                    rem_d     = op_len;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (can_load) begin
                    do_data_d  = decrypt_q ? {8'h43, 8'h00, len_q} : {8'h52, 8'h00, len_q};
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    if (len_q == 16'd0)
                        state_d = decrypt_q ? S_AUTH : S_TAG_HDR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bdo_fire) begin
                    do_data_d  = bdo & data_mask;
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    rem_d      = rem_q - rem_step;
                    if (rem_q == rem_step)
                        state_d = decrypt_q ? S_AUTH : S_TAG_HDR;
                end
            end
            S_TAG_HDR: begin
                if (can_load) begin
                    do_data_d  = {8'h83, 8'h00, 16'(TAG_WORDS * 4)};
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_TAG;
                end
            end
            S_TAG: begin
                if (bdo_fire) begin
                    do_data_d  = bdo;
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q == 8'(TAG_WORDS - 1)) begin
                        verdict_d = 1'b1;
                        state_d   = S_STATUS;
                    end
                end
            end
            S_AUTH: begin
                if (msg_auth_valid) begin
                    verdict_d = msg_auth;
                    state_d   = S_STATUS;
                end
            end
            S_STATUS: begin
                if (can_load) begin
                    do_data_d  = verdict_q ? STATUS_SUCCESS : STATUS_FAILURE;
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        can_load       = !do_valid_q || do_ready;
        op_ready       = (state_q == S_IDLE);
        bdo_ready      = ((state_q == S_DATA) || (state_q == S_TAG)) && can_load;
        msg_auth_ready = (state_q == S_AUTH);
        bdo_fire       = bdo_valid && bdo_ready;
    end

    assign do_data  = do_data_q;
    assign do_valid = do_valid_q;
    assign do_last  = do_last_q;

endmodule

// File: tb/tb_lwc_post_processor.sv
// Randomized bench for lwc_post_processor: a queue-based model of the expected
// do_data stream is compared word by word with the DUT output.
module tb_lwc_post_processor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic        op_decrypt = 1'b0;
    logic [15:0] op_len = '0;
    logic [31:0] bdo = '0;
    logic        bdo_valid = 1'b0;
    logic        bdo_ready;
    logic        msg_auth = 1'b0;
    logic        msg_auth_valid = 1'b0;
    logic        msg_auth_ready;
    logic [31:0] do_data;
    logic        do_valid;
    logic        do_ready = 1'b0;
    logic        do_last;

    int n_checks = 0;
    int n_errors = 0;

    lwc_post_processor #(
        .TAG_WORDS      (4),
        .STATUS_SUCCESS (32'hE000_0000),
        .STATUS_FAILURE (32'hF000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_decrypt     (op_decrypt),
        .op_len         (op_len),
        .bdo            (bdo),
        .bdo_valid      (bdo_valid),
        .bdo_ready      (bdo_ready),
        .msg_auth       (msg_auth),
        .msg_auth_valid (msg_auth_valid),
        .msg_auth_ready (msg_auth_ready),
        .do_data        (do_data),
        .do_valid       (do_valid),
        .do_ready       (do_ready),
        .do_last        (do_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_do_valid"}, 32'(do_valid), 32'd0);
        check({tag, "_do_last"}, 32'(do_last), 32'd0);
        check({tag, "_do_data"}, do_data, 32'd0);
        check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        check({tag, "_bdo_ready"}, 32'(bdo_ready), 32'd0);
        check({tag, "_auth_ready"}, 32'(msg_auth_ready), 32'd0);
    endtask

    // rmode: 0 = do_ready always 1, 1 = toggling, 2 = random.
    // abort_at >= 0 pulses reset once that many bdo words have been consumed.
    task automatic run_op(input bit dec, input int unsigned len, input bit verdict,
                          input int unsigned rmode, input int abort_at);
        logic [31:0] src[$];
        logic [31:0] exp_q[$];
        bit          exp_last[$];
        logic [31:0] v, m, w_exp, prev_data;
        bit          l_exp, prev_stall, op_pend, done, aborted;
        int unsigned nw, nb, bidx, auth_cnt, n_out, exp_total, cyc;

        nw = (len + 3) / 4;
        exp_q.push_back(dec ? (32'h4300_0000 | len) : (32'h5200_0000 | len));
        exp_last.push_back(1'b0);
        for (int unsigned w = 0; w < nw; w++) begin
            v  = $urandom;
            m  = v;
            nb = (len - 4 * w >= 4) ? 4 : len - 4 * w;
            for (int unsigned b = nb; b < 4; b++) m[31 - 8 * b -: 8] = 8'h00;
            src.push_back(v);
            exp_q.push_back(m);
            exp_last.push_back(1'b0);
        end
        if (!dec) begin
            exp_q.push_back(32'h8300_0010);
            exp_last.push_back(1'b0);
            for (int unsigned t = 0; t < 4; t++) begin
                v = $urandom;
                src.push_back(v);
                exp_q.push_back(v);
                exp_last.push_back(1'b0);
            end
        end
        exp_q.push_back((dec && !verdict) ? 32'hF000_0000 : 32'hE000_0000);
        exp_last.push_back(1'b1);
        exp_total = exp_q.size();

        bidx = 0; auth_cnt = 0; n_out = 0; cyc = 0;
        prev_stall = 1'b0; prev_data = '0;
        op_pend = 1'b1; done = 1'b0; aborted = 1'b0;

        while (!done && !aborted && cyc < 5000) begin
            @(negedge clk);
            if (abort_at >= 0 && bidx == 32'(abort_at) && !op_pend) begin
                rst = 1'b0;
                @(negedge clk);
                #1;
                check_idle_outputs("abort");
                rst = 1'b1;
                aborted = 1'b1;
            end else begin
                op_valid   = op_pend;
                op_decrypt = dec;
                op_len     = len[15:0];
                case (rmode)
                    0:       do_ready = 1'b1;
                    1:       do_ready = cyc[0];
                    default: do_ready = 1'($urandom_range(0, 1));
                endcase
                if (bidx < src.size()) begin
                    bdo_valid = ($urandom_range(0, 3) != 0);
                    bdo       = bdo_valid ? src[bidx] : $urandom;
                end else begin
                    bdo_valid = 1'b1;
                    bdo       = 32'hDEAD_BEEF;
                end
                msg_auth_valid = (auth_cnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                msg_auth       = verdict;
                #1;
                if (prev_stall) begin
                    check("hold_valid", 32'(do_valid), 32'd1);
                    check("hold_data", do_data, prev_data);
                end
                if (bidx >= src.size()) check("bdo_ready_after_stream", 32'(bdo_ready), 32'd0);
                if (op_valid && op_ready) op_pend = 1'b0;
                if (bdo_valid && bdo_ready && bidx < src.size()) bidx++;
                if (msg_auth_valid && msg_auth_ready) auth_cnt++;
                if (do_valid && do_ready) begin
                    if (exp_q.size() == 0) begin
                        check("do_count", 32'(n_out + 1), 32'(exp_total));
                    end else begin
                        w_exp = exp_q.pop_front();
                        l_exp = exp_last.pop_front();
                        check("do_data", do_data, w_exp);
                        check("do_last", 32'(do_last), 32'(l_exp));
                        if (l_exp) done = 1'b1;
                    end
                    n_out++;
                end
                prev_stall = do_valid && !do_ready;
                prev_data  = do_data;
                cyc++;
            end
        end
        op_valid       = 1'b0;
        msg_auth_valid = 1'b0;
        if (!aborted) begin
            check("words_left", 32'(exp_q.size()), 32'd0);
            check("bdo_consumed", bidx, 32'(src.size()));
            check("auth_consumed", auth_cnt, dec ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;

        run_op(1'b0, 5, 1'b1, 0, -1);
        run_op(1'b1, 8, 1'b1, 0, -1);
        run_op(1'b1, 3, 1'b0, 0, -1);
        run_op(1'b0, 0, 1'b1, 0, -1);
        run_op(1'b1, 0, 1'b0, 2, -1);
        run_op(1'b0, 12, 1'b1, 1, -1);
        run_op(1'b0, 12, 1'b1, 0, 1);
        run_op(1'b0, 4, 1'b1, 0, -1);
        run_op(1'b1, 1000, 1'b1, 2, -1);

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 40),
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), -1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
